// File: rtl/mmio_periph_hub.sv
// Memory-mapped I/O hub: decodes a 256-byte window, shields the data RAM from
// writes inside it and serves output words, synchronised switches and a compare timer.
module mmio_periph_hub #(
  parameter logic [31:0] BASE_ADDR = 32'h1004_F000,
  parameter int          NUM_OUT   = 4,
  parameter int          SW_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [31:0]            addr,
  input  logic [31:0]            datain,
  input  logic                   we,
  input  logic [2:0]             memop,
  input  logic [31:0]            ram_dataout,
  output logic [31:0]            dataout,
  output logic                   ram_we,
  input  logic [SW_WIDTH-1:0]    sw_in,
  output logic [NUM_OUT*32-1:0]  out_regs,
  output logic                   timer_irq
);

  localparam logic [5:0] W_SW     = 6'h10;
  localparam logic [5:0] W_TCOUNT = 6'h11;
  localparam logic [5:0] W_TCMP   = 6'h12;
  localparam logic [5:0] W_STATUS = 6'h13;
  localparam logic [5:0] W_CTRL   = 6'h14;

  // An empty mask marks an illegal access size.
  function automatic logic [31:0] lane_mask(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      3'b000, 3'b100: lane_mask = 32'h0000_00FF << {lo, 3'b000};
      3'b001, 3'b101: lane_mask = lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      3'b010:         lane_mask = 32'hFFFF_FFFF;
      default:        lane_mask = '0;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'b000, 3'b100: lane_data = {4{d[7:0]}};
      3'b001, 3'b101: lane_data = {2{d[15:0]}};
      default:        lane_data = d;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] m);
    merge = (old & ~m) | (d & m);
  endfunction

  logic [31:0]         out_q [NUM_OUT];
  logic [31:0]         tcount_q, tcmp_q;
  logic [1:0]          ctrl_q, status_q;
  logic [SW_WIDTH-1:0] sw_p0, sw_p1;

  logic        hit, wr_hit, wr_ok, memop_ok, is_out, mapped, werr_set, match_now;
  logic [5:0]  widx;
  logic [31:0] wmask, wdata, rd_word;
  logic [1:0]  clr;

  assign hit      = (addr[31:8] == BASE_ADDR[31:8]);
  assign widx     = addr[7:2];
  assign wmask    = lane_mask(memop, addr[1:0]);
  assign wdata    = lane_data(memop, datain);
  assign memop_ok = (wmask != '0);
  assign wr_hit   = hit & we;
  assign wr_ok    = wr_hit & memop_ok;
  assign is_out   = (int'(widx) < NUM_OUT);
  assign mapped   = is_out | (widx == W_TCOUNT) | (widx == W_TCMP) |
                    (widx == W_STATUS) | (widx == W_CTRL);
  assign werr_set = wr_hit & (~memop_ok | ~mapped);
  assign match_now = ctrl_q[0] & (tcount_q == tcmp_q);
  assign clr      = (wr_ok && widx == W_STATUS) ? (wdata[1:0] & wmask[1:0]) : 2'b00;

  assign ram_we    = hit ? 1'b0 : we;
  assign dataout   = hit ? rd_word : ram_dataout;
  assign timer_irq = status_q[0];

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_regs[32*k +: 32] = out_q[k];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else if (wr_ok && is_out) begin
      for (int k = 0; k < NUM_OUT; k++)
        if (int'(widx) == k) out_q[k] <= merge(out_q[k], wdata, wmask);
    end
  end

  // A CPU write to TCOUNT takes precedence over increment and auto-reload.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tcount_q <= '0;
      tcmp_q   <= '1;
      ctrl_q   <= '0;
      status_q <= '0;
    end else begin
      if (wr_ok && widx == W_TCOUNT)
        tcount_q <= merge(tcount_q, wdata, wmask);
      else if (ctrl_q[0])
        tcount_q <= (match_now && ctrl_q[1]) ? '0 : tcount_q + 32'd1;
      if (wr_ok && widx == W_TCMP)
        tcmp_q <= merge(tcmp_q, wdata, wmask);
      if (wr_ok && widx == W_CTRL)
        ctrl_q <= (ctrl_q & ~wmask[1:0]) | (wdata[1:0] & wmask[1:0]);
      status_q[0] <= match_now | (status_q[0] & ~clr[0]);
      status_q[1] <= werr_set  | (status_q[1] & ~clr[1]);
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw_in;
      sw_p1 <= sw_p0;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_OUT; k++)
      if (int'(widx) == k) rd_word = out_q[k];
    case (widx)
      W_SW:     rd_word = 32'(sw_p1);
      W_TCOUNT: rd_word = tcount_q;
      W_TCMP:   rd_word = tcmp_q;
      W_STATUS: rd_word = {30'b0, status_q};
      W_CTRL:   rd_word = {30'b0, ctrl_q};
      default:  ;
    endcase
  end

endmodule
